fht_input_loader: RTL and testbench
===================================

// Module: fht_input_loader
// PURPOSE
//  Upstream neighbour of fht_control. Accepts a serial sample stream via valid/ready handshake.
//  Writes 4*2^A_BIT samples into the four FHT RAM banks in bit-reversed order.
//  Pulses oSTART to fht_control, then holds off new input until the transform reports done on oRDY.
// PARAMETERS
//  A_BIT  8   bank address width; frame = 4*2^A_BIT points (default 1024)
//  D_BIT  16  sample width
// PORTS
//  iCLK       in   1      clock; all logic on rising edge
//  iRESET     in   1      synchronous reset, active low
//  iDATA      in   D_BIT  input sample
//  iVALID     in   1      iDATA valid
//  oREADY     out  1      loader accepts sample this cycle
//  iFHT_RDY   in   1      fht_control oRDY (1 = idle/done)
//  oSTART     out  1      one-cycle start pulse to fht_control iSTART
//  oADDR_WR   out  A_BIT  bank write address
//  oDATA      out  D_BIT  bank write data
//  oBANK_WE   out  4      one-hot bank write enable, bank 0..3
//  oBUSY      out  1      1 from first accepted sample until transform done
// BEHAVIOUR
//  - Reset (iRESET=0 at edge): state IDLE, sample cnt n=0; oREADY=0, oSTART=0, oBANK_WE=0,
//    oADDR_WR=0, oDATA=0, oBUSY=0. Reset mid-load or mid-transform discards the partial frame.
//  - FSM:
//    IDLE:  oREADY=0; -> LOAD when iFHT_RDY=1.
//    LOAD:  oREADY=1; on iVALID&oREADY accept sample, n++.
//           Accepting n=4*2^A_BIT-1 -> START (oREADY drops next cycle).
//           iVALID gaps allowed; n holds.
//    START: oSTART=1 for exactly this cycle; -> WAIT_BSY.
//    WAIT_BSY: -> WAIT_DONE when iFHT_RDY=0.
//    WAIT_DONE: -> LOAD when iFHT_RDY=1.
//  - Address map: n is A_BIT+2 bits; r = bit-reverse(n) over A_BIT+2 bits.
//    Bank = r[A_BIT+1:A_BIT]; oADDR_WR = r[A_BIT-1:0].
//  - Write latency: sample accepted at edge t -> oBANK_WE/oADDR_WR/oDATA valid during cycle t+1,
//    for one cycle. oBANK_WE=0 on cycles with no accept.
//    oSTART is asserted the cycle after the last write cycle, so all writes land before start.
//  - Exactly one oBANK_WE bit high per accepted sample; never two.
//  - oREADY=0 in IDLE/START/WAIT_*; iVALID is ignored there (no write, n unchanged).
//  - oBUSY: set on first accept of a frame; cleared on the WAIT_DONE->LOAD transition.
//  - Counter wrap: n returns to 0 on the START transition. It never exceeds 4*2^A_BIT-1.
//  - iFHT_RDY=0 seen in IDLE: stay IDLE; a transform from an earlier session must finish first.
//  - iFHT_RDY never dropping in WAIT_BSY: remain there. No timeout.
// CONFIGURATION
//  FHT_LOADER_BITREV_BYPASS_EN:
//    defined     -> natural order: bank = n[A_BIT+1:A_BIT], oADDR_WR = n[A_BIT-1:0]
//                   (used when the source already delivers bit-reversed data).
//    not defined -> bit-reversed mapping as above (default build).
//    FSM, handshake and latency are identical in both builds.
// TESTING (A_BIT=8, D_BIT=16, macro off unless stated)
//  1. Reset, iFHT_RDY=1, stream n=0..3 back to back.
//     -> writes {bank0,addr0}, {bank2,addr0}, {bank1,addr0}, {bank3,addr0}.
//     Each WE is one cycle after its accept; n=4 -> bank0 addr128.
//  2. Full frame of 1024 samples with data=n.
//     -> each bank/addr pair written exactly once; oSTART single pulse the cycle after the last WE.
//     oREADY=0 from then until iFHT_RDY goes 0 then back to 1.
//  3. iVALID toggling 1/0 plus iVALID=1 while in WAIT_DONE.
//     -> no extra writes; n advances only on handshakes; oBUSY stays 1.
//  4. Reset asserted after 500 samples.
//     -> all outputs 0 next cycle; next frame starts at n=0 (bank0 addr0).
//  5. Macro on, n=1,2,256 -> bank0 addr1, bank0 addr2, bank1 addr0.
//  6. Back-to-back frames with the fht_control model.
//     -> second frame's first write occurs only after oRDY returns to 1.

Source files
------------

// File: rtl/fht_input_loader.sv
// Serial loader for four FHT banks, bit-reversed unless FHT_LOADER_BITREV_BYPASS_EN (natural order).
// Write 1 cycle after accept; oREADY low outside LOAD until fht_control reports done.
module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic             oSTART,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA,
  output logic [3:0]       oBANK_WE,
  output logic             oBUSY
);

  localparam int N_BIT = A_BIT + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BSY,
    S_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_BIT-1:0] n_q, n_d;
  logic [N_BIT-1:0] map_n;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [3:0]       we_q, we_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [D_BIT-1:0] data_q, data_d;
  logic             accept;

  always_comb begin
    map_n = '0;
`ifdef FHT_LOADER_BITREV_BYPASS_EN
    map_n = n_q;
`else
    for (int i = 0; i < N_BIT; i++) begin
      map_n[i] = n_q[N_BIT-1-i];
    end
`endif
  end

  assign oREADY = (state_q == S_LOAD);
  assign accept = iVALID & oREADY;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    we_d    = 4'b0000;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (iFHT_RDY) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          we_d   = 4'b0001 << map_n[N_BIT-1 -: 2];
          addr_d = map_n[A_BIT-1:0];
          data_d = iDATA;
          busy_d = 1'b1;
          if (n_q == {N_BIT{1'b1}}) begin
            n_d     = '0;
            state_d = S_START;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      // oSTART is registered, so it lands one cycle after the final bank write.
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT_BSY;
      end
      S_WAIT_BSY: begin
        if (!iFHT_RDY) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (iFHT_RDY) begin
          state_d = S_LOAD;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      we_q    <= 4'b0000;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oSTART   = start_q;
  assign oBANK_WE = we_q;
  assign oADDR_WR = addr_q;
  assign oDATA    = data_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader (A_BIT=8, D_BIT=16) with a simple fht_control model.
module tb_fht_input_loader;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic [15:0] iDATA;
  logic        iVALID;
  logic        oREADY;
  logic        fht_rdy;
  logic        oSTART;
  logic [7:0]  oADDR_WR;
  logic [15:0] oDATA;
  logic [3:0]  oBANK_WE;
  logic        oBUSY;

  fht_input_loader #(.A_BIT(8), .D_BIT(16)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
    .iFHT_RDY(fht_rdy), .oSTART(oSTART), .oADDR_WR(oADDR_WR), .oDATA(oDATA),
    .oBANK_WE(oBANK_WE), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [3:0]  we;
    logic [7:0]  a;
    logic [15:0] d;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tb_n = 0;
  int   start_cnt = 0;
  int   last_we_cyc = -10;
  logic model_done = 1'b1;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] exp_map(input int n);
    logic [9:0] v;
    logic [9:0] r;
    v = n[9:0];
`ifdef FHT_LOADER_BITREV_BYPASS_EN
    r = v;
`else
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
`endif
    return {4'b0001 << r[9:8], r[7:0]};
  endfunction

  // fht_control stand-in: drops ready shortly after start, raises it when "done".
  initial fht_rdy = 1'b1;
  always @(negedge iCLK) begin
    if (oSTART === 1'b1) begin
      model_done = 1'b0;
      repeat (2) @(posedge iCLK);
      #1 fht_rdy = 1'b0;
      repeat (20) @(posedge iCLK);
      #1 fht_rdy = 1'b1;
      model_done = 1'b1;
    end
  end

  // Write/start monitor, sampled mid-cycle.
  always @(negedge iCLK) begin
    if (oBANK_WE !== 4'b0000) begin
      if (q.size() == 0) begin
        chk("extra_write_we", {28'd0, oBANK_WE}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_we", {28'd0, oBANK_WE}, {28'd0, e.we});
        chk("write_addr", {24'd0, oADDR_WR}, {24'd0, e.a});
        chk("write_data", {16'd0, oDATA}, {16'd0, e.d});
        chk("write_cycle", cyc, e.cyc);
      end
      last_we_cyc = cyc;
    end
    if (oSTART === 1'b1) begin
      start_cnt++;
      chk("start_after_last_we", cyc, last_we_cyc + 1);
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] we, input logic [7:0] a);
    int guard;
    exp_t e;
    guard = 0;
    iVALID = 1'b1;
    iDATA  = d;
    @(negedge iCLK);
    while (oREADY !== 1'b1 && guard < 200) begin
      @(negedge iCLK);
      guard++;
    end
    if (oREADY !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.we = we; e.a = a; e.d = d; e.cyc = cyc + 1;
      q.push_back(e);
      tb_n = (tb_n + 1) % 1024;
    end
    @(posedge iCLK);
    #1 iVALID = 1'b0;
  endtask

  task automatic send_n(input int gap);
    logic [11:0] m;
    m = exp_map(tb_n);
    send(16'(tb_n), m[11:8], m[7:0]);
    for (int g = 0; g < gap; g++) begin
      @(negedge iCLK);
      if (g == 0 && tb_n < 8) chk("busy_in_gap", {31'd0, oBUSY}, 32'd1);
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic wait_start(input int want);
    int guard;
    guard = 0;
    while (start_cnt < want && guard < 20) begin
      @(negedge iCLK);
      guard++;
    end
    chk("start_pulse_count", start_cnt, want);
  endtask

  // Hold iVALID toggling while the transform runs; ready must only return after done.
  task automatic wait_reload();
    int guard;
    guard = 0;
    @(negedge iCLK);
    while (oREADY !== 1'b1 && guard < 200) begin
      iVALID = guard[0];
      iDATA  = 16'hdead;
      if (guard == 5) chk("busy_while_transform", {31'd0, oBUSY}, 32'd1);
      @(negedge iCLK);
      guard++;
    end
    iVALID = 1'b0;
    chk("ready_only_after_done", {31'd0, model_done}, 32'd1);
    chk("busy_cleared_on_reload", {31'd0, oBUSY}, 32'd0);
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRESET = 1'b0;
    iVALID = 1'b1;
    iDATA  = 16'h1234;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset_ready", {31'd0, oREADY}, 32'd0);
    chk("reset_start", {31'd0, oSTART}, 32'd0);
    chk("reset_we", {28'd0, oBANK_WE}, 32'd0);
    chk("reset_addr", {24'd0, oADDR_WR}, 32'd0);
    chk("reset_data", {16'd0, oDATA}, 32'd0);
    chk("reset_busy", {31'd0, oBUSY}, 32'd0);
    iVALID = 1'b0;
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;

    // Frame 1: first five samples against fixed addresses, then a gappy stream.
`ifdef FHT_LOADER_BITREV_BYPASS_EN
    send(16'd0, 4'b0001, 8'd0);
    send(16'd1, 4'b0001, 8'd1);
    send(16'd2, 4'b0001, 8'd2);
    send(16'd3, 4'b0001, 8'd3);
    send(16'd4, 4'b0001, 8'd4);
`else
    send(16'd0, 4'b0001, 8'd0);
    send(16'd1, 4'b0100, 8'd0);
    send(16'd2, 4'b0010, 8'd0);
    send(16'd3, 4'b1000, 8'd0);
    send(16'd4, 4'b0001, 8'd128);
`endif
    while (tb_n != 0) send_n((tb_n < 300) ? (tb_n % 3) : 0);
    wait_start(1);
    chk("queue_drained_f1", q.size(), 32'd0);
    wait_reload();
    chk("single_start_f1", start_cnt, 32'd1);

    // Frame 2: reset after 500 samples discards the partial frame.
    for (int i = 0; i < 500; i++) send_n(0);
    iRESET = 1'b0;
    @(negedge iCLK);
    @(posedge iCLK);
    #1;
    @(negedge iCLK);
    chk("midreset_ready", {31'd0, oREADY}, 32'd0);
    chk("midreset_we", {28'd0, oBANK_WE}, 32'd0);
    chk("midreset_addr", {24'd0, oADDR_WR}, 32'd0);
    chk("midreset_data", {16'd0, oDATA}, 32'd0);
    chk("midreset_busy", {31'd0, oBUSY}, 32'd0);
    chk("midreset_queue", q.size(), 32'd0);
    tb_n = 0;
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;

    // Frame 3: restarts at n=0, full back-to-back frame and second transform.
    send(16'h00aa, 4'b0001, 8'd0);
`ifdef FHT_LOADER_BITREV_BYPASS_EN
    send(16'h00bb, 4'b0001, 8'd1);
`else
    send(16'h00bb, 4'b0100, 8'd0);
`endif
    while (tb_n != 0) send_n(0);
    wait_start(2);
    chk("queue_drained_f3", q.size(), 32'd0);
    wait_reload();
    chk("single_start_f3", start_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
